// File: rtl/pkg_opengpu.sv
// Shared types and helpers for the scalar issue/operand path.
// Register-file banking: bank is the index LSB, row is the rest.
package pkg_opengpu;

  localparam int XLEN          = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int RF_BANKS      = 2;
  localparam int RF_ROW_WIDTH  = 4;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [2:0] {
    OC_IDLE, OC_READ, OC_READ2, OC_WAIT, OC_VALID
  } oc_state_t;

  function automatic logic rf_bank_of(
    input logic [REG_IDX_WIDTH-1:0] idx
  );
    return (idx & REG_IDX_WIDTH'(1)) != '0;
  endfunction

  function automatic logic [RF_ROW_WIDTH-1:0] rf_row_of(
    input logic [REG_IDX_WIDTH-1:0] idx
  );
    return RF_ROW_WIDTH'(idx >> 1);
  endfunction

endpackage

// File: rtl/operand_collector.sv
// Operand collect stage: reads rs1/rs2 from a two-bank RF,
// serialising same-bank reads, then hands off to execute.
module operand_collector
  import pkg_opengpu::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  alu_op_t                       issue_alu_op,
  input  logic [REG_IDX_WIDTH-1:0]      issue_rs1,
  input  logic [REG_IDX_WIDTH-1:0]      issue_rs2,
  input  logic [REG_IDX_WIDTH-1:0]      issue_rd,
  input  logic                          issue_use_imm,
  input  logic [DATA_WIDTH-1:0]         issue_imm,
  output logic [RF_BANKS-1:0]           rf_rd_en,
  output logic [RF_BANKS-1:0][RF_ROW_WIDTH-1:0] rf_rd_addr,
  input  logic [RF_BANKS-1:0][DATA_WIDTH-1:0]   rf_rd_data,
  output logic                          ex_valid,
  input  logic                          ex_ready,
  output logic [DATA_WIDTH-1:0]         ex_operand_a,
  output logic [DATA_WIDTH-1:0]         ex_operand_b,
  output alu_op_t                       ex_alu_op,
  output logic [REG_IDX_WIDTH-1:0]      ex_rd,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  oc_state_t                  state_q, state_d;
  logic [REG_IDX_WIDTH-1:0]   rs1_q, rs1_d;
  logic [REG_IDX_WIDTH-1:0]   rs2_q, rs2_d;
  logic [REG_IDX_WIDTH-1:0]   rd_q, rd_d;
  logic                       use_imm_q, use_imm_d;
  alu_op_t                    alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0]      opa_q, opa_d;
  logic [DATA_WIDTH-1:0]      opb_q, opb_d;
  logic [CNT_WIDTH-1:0]       conflict_cnt_q, conflict_cnt_d;

  logic need1, need2, same, cfl, b1, b2;
  logic i_need1, i_need2, i_same, i_cfl, i_any;
  logic accept;

  // Read plan of the held instruction
  assign need1 = rs1_q != '0;
  assign same  = !use_imm_q && (rs1_q == rs2_q);
  assign need2 = !use_imm_q && (rs2_q != '0) && !same;
  assign b1    = rf_bank_of(rs1_q);
  assign b2    = rf_bank_of(rs2_q);
  assign cfl   = need1 && need2 && (b1 == b2);

  // Read plan of the incoming instruction
  assign i_need1 = issue_rs1 != '0;
  assign i_same  = !issue_use_imm && (issue_rs1 == issue_rs2);
  assign i_need2 = !issue_use_imm && (issue_rs2 != '0) && !i_same;
  assign i_cfl   = i_need1 && i_need2 &&
                   (rf_bank_of(issue_rs1) == rf_bank_of(issue_rs2));
  assign i_any   = i_need1 || i_need2;

  always_comb begin
    state_d        = state_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    use_imm_d      = use_imm_q;
    alu_op_d       = alu_op_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    conflict_cnt_d = conflict_cnt_q;
    issue_ready    = 1'b0;
    ex_valid       = 1'b0;
    rf_rd_en       = '0;
    rf_rd_addr     = '0;
    accept         = 1'b0;

    unique case (state_q)
      OC_IDLE: issue_ready = 1'b1;
      OC_READ: begin
        if (need1) begin
          rf_rd_en[b1]   = 1'b1;
          rf_rd_addr[b1] = rf_row_of(rs1_q);
        end
        if (need2 && !cfl) begin
          rf_rd_en[b2]   = 1'b1;
          rf_rd_addr[b2] = rf_row_of(rs2_q);
        end
        state_d = cfl ? OC_READ2 : OC_WAIT;
      end
      OC_READ2: begin
        opa_d          = rf_rd_data[b1];
        rf_rd_en[b2]   = 1'b1;
        rf_rd_addr[b2] = rf_row_of(rs2_q);
        state_d        = OC_WAIT;
      end
      OC_WAIT: begin
        if (cfl) begin
          opb_d = rf_rd_data[b2];
        end else begin
          if (need1) opa_d = rf_rd_data[b1];
          if (need1 && same) opb_d = rf_rd_data[b1];
          if (need2) opb_d = rf_rd_data[b2];
        end
        state_d = OC_VALID;
      end
      OC_VALID: begin
        ex_valid    = 1'b1;
        issue_ready = ex_ready;
        if (ex_ready) state_d = OC_IDLE;
      end
      default: state_d = OC_IDLE;
    endcase

    if (flush) begin
      issue_ready = 1'b0;
      state_d     = OC_IDLE;
    end
    if (rst) issue_ready = 1'b0;

    accept = issue_valid && issue_ready;
    if (accept) begin
      rs1_d     = issue_rs1;
      rs2_d     = issue_rs2;
      rd_d      = issue_rd;
      use_imm_d = issue_use_imm;
      alu_op_d  = issue_alu_op;
      opa_d     = '0;
      opb_d     = issue_use_imm ? issue_imm : '0;
      state_d   = i_any ? OC_READ : OC_VALID;
      if (i_cfl && conflict_cnt_q != {CNT_WIDTH{1'b1}})
        conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= OC_IDLE;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      use_imm_q      <= 1'b0;
      alu_op_q       <= ALU_NOP;
      opa_q          <= '0;
      opb_q          <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      use_imm_q      <= use_imm_d;
      alu_op_q       <= alu_op_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign ex_operand_a = opa_q;
  assign ex_operand_b = opb_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_rd        = rd_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: RF bank model, scoreboard of
// expected operands, and directed latency/port-level checks.
module tb_operand_collector;
  import pkg_opengpu::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst, flush, issue_valid, issue_ready;
  logic issue_use_imm, ex_valid, ex_ready;
  alu_op_t issue_alu_op, ex_alu_op;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, ex_rd;
  logic [DW-1:0] issue_imm, ex_operand_a, ex_operand_b;
  logic [1:0] rf_rd_en;
  logic [1:0][3:0] rf_rd_addr;
  logic [1:0][DW-1:0] rf_rd_data;
  logic [CW-1:0] conflict_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] rf [32];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    rd;
    alu_op_t       op;
  } exp_t;
  exp_t q[$];
  logic [CW-1:0] model_cnt = '0;

  operand_collector #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_op(issue_alu_op), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Banked RF: data one cycle after enable, junk otherwise
  always @(posedge clk)
    for (int p = 0; p < 2; p++)
      rf_rd_data[p] <= rf_rd_en[p] ?
        rf[{rf_rd_addr[p], p[0]}] : 32'hDEAD_0000 + p;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected operands straight from RF contents
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("conflict_cnt", conflict_cnt, model_cnt);
      if (ex_valid) begin
        if (q.size() == 0) begin
          check("ex_valid_without_expect", 64'(q.size()), 1);
        end else begin
          check("ex_a", ex_operand_a, q[0].a);
          check("ex_b", ex_operand_b, q[0].b);
          check("ex_rd", ex_rd, q[0].rd);
          check("ex_op", ex_alu_op, q[0].op);
          if (ex_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (issue_valid && issue_ready) begin
        e.a  = (issue_rs1 == 0) ? '0 : rf[issue_rs1];
        e.b  = issue_use_imm ? issue_imm :
               (issue_rs2 == 0) ? '0 : rf[issue_rs2];
        e.rd = issue_rd;
        e.op = issue_alu_op;
        q.push_back(e);
        if (issue_rs1 != 0 && issue_rs2 != 0 && !issue_use_imm &&
            issue_rs1 != issue_rs2 &&
            issue_rs1[0] == issue_rs2[0] && model_cnt != '1)
          model_cnt = model_cnt + 1'b1;
      end
    end else begin
      q.delete();
      model_cnt = '0;
    end
  end

  int lat;
  logic [1:0] en_log [1:8];
  logic [1:0][3:0] addr_log [1:8];
  logic [DW-1:0] a_cap, b_cap;

  task automatic drive(alu_op_t op, logic [4:0] r1, logic [4:0] r2,
                       logic [4:0] rd, logic ui, logic [DW-1:0] imm);
    issue_alu_op  = op;
    issue_rs1     = r1;
    issue_rs2     = r2;
    issue_rd      = rd;
    issue_use_imm = ui;
    issue_imm     = imm;
    issue_valid   = 1'b1;
  endtask

  task automatic run(alu_op_t op, logic [4:0] r1, logic [4:0] r2,
                     logic [4:0] rd, logic ui, logic [DW-1:0] imm);
    int t0;
    bit got;
    @(posedge clk); #1;
    drive(op, r1, r2, rd, ui, imm);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (issue_ready) begin got = 1; break; end
    end
    check("accept_timeout", got, 1);
    t0 = cyc;
    @(posedge clk); #1 issue_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      en_log[k]   = rf_rd_en;
      addr_log[k] = rf_rd_addr;
      if (ex_valid && lat == 0) begin
        lat   = cyc - t0;
        a_cap = ex_operand_a;
        b_cap = ex_operand_b;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i * 32'h101;
    rf[0] = 32'hBAD0_BAD0;
    rf[3] = 32'h10; rf[4] = 32'h20;
    rf[2] = 32'h222; rf[6] = 32'h666; rf[5] = 32'h555;
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    issue_valid = 1'b0;
    drive(ALU_NOP, 5'd0, 5'd0, 5'd0, 1'b0, '0);
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ready", issue_ready, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_rd_en", rf_rd_en, 0);
    check("rst_cnt", conflict_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_issue_ready", issue_ready, 1);
    check("post_rst_a", ex_operand_a, 0);
    check("post_rst_op", ex_alu_op, ALU_NOP);

    // Different banks: parallel reads
    run(ALU_ADD, 5'd3, 5'd4, 5'd7, 1'b0, '0);
    check("t1_en", en_log[1], 2'b11);
    check("t1_row_b1", addr_log[1][1], 1);
    check("t1_row_b0", addr_log[1][0], 2);
    check("t1_en2", en_log[2], 0);
    check("t1_lat", lat, 3);
    check("t1_a", a_cap, 32'h10);
    check("t1_b", b_cap, 32'h20);
    check("t1_cnt", conflict_cnt, 0);

    // Same bank: serialised reads
    run(ALU_SUB, 5'd2, 5'd6, 5'd8, 1'b0, '0);
    check("t2_en1", en_log[1], 2'b01);
    check("t2_row1", addr_log[1][0], 1);
    check("t2_en2", en_log[2], 2'b01);
    check("t2_row2", addr_log[2][0], 3);
    check("t2_en3", en_log[3], 0);
    check("t2_lat", lat, 4);
    check("t2_a", a_cap, 32'h222);
    check("t2_b", b_cap, 32'h666);
    check("t2_cnt", conflict_cnt, 1);

    // Same register on both sources
    run(ALU_XOR, 5'd5, 5'd5, 5'd9, 1'b0, '0);
    check("t3_en1", en_log[1], 2'b10);
    check("t3_row1", addr_log[1][1], 2);
    check("t3_en2", en_log[2], 0);
    check("t3_lat", lat, 3);
    check("t3_a", a_cap, 32'h555);
    check("t3_b", b_cap, 32'h555);
    check("t3_cnt", conflict_cnt, 1);

    // x0 plus immediate: no reads at all
    run(ALU_OR, 5'd0, 5'd6, 5'd10, 1'b1, 32'hFFFF_FFFF);
    check("t4_en1", en_log[1], 0);
    check("t4_lat", lat, 1);
    check("t4_a", a_cap, 0);
    check("t4_b", b_cap, 32'hFFFF_FFFF);

    // Back-pressure then same-cycle accept
    ex_ready = 1'b0;
    run(ALU_AND, 5'd7, 5'd8, 5'd11, 1'b0, '0);
    check("t5_lat", lat, 3);
    @(posedge clk); #1;
    drive(ALU_SLT, 5'd10, 5'd11, 5'd12, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_hold_valid", ex_valid, 1);
      check("t5_hold_ready", issue_ready, 0);
      check("t5_hold_a", ex_operand_a, a_cap);
      check("t5_hold_b", ex_operand_b, b_cap);
      check("t5_hold_rd", ex_rd, 11);
    end
    @(posedge clk); #1 ex_ready = 1'b1;
    @(negedge clk);
    check("t5_same_cycle_accept", issue_ready, 1);
    @(posedge clk); #1 issue_valid = 1'b0;
    @(negedge clk);
    check("t5_next_not_valid", ex_valid, 0);
    repeat (6) @(negedge clk);

    // Flush during the second serialised read
    @(posedge clk); #1;
    drive(ALU_ADD, 5'd2, 5'd6, 5'd13, 1'b0, '0);
    @(negedge clk);
    check("t6_accept", issue_ready, 1);
    @(posedge clk); #1 issue_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("t6_flush_ready", issue_ready, 0);
    check("t6_read2_en", rf_rd_en, 2'b01);
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_valid", ex_valid, 0);
    end
    check("t6_idle_ready", issue_ready, 1);
    check("t6_cnt", conflict_cnt, 2);

    // Counter saturation, then reset clears it
    @(posedge clk); #1;
    force dut.conflict_cnt_q = 16'hFFFE;
    model_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.conflict_cnt_q;
    run(ALU_SUB, 5'd2, 5'd6, 5'd14, 1'b0, '0);
    check("t7_cnt_max", conflict_cnt, 16'hFFFF);
    run(ALU_SUB, 5'd1, 5'd3, 5'd15, 1'b0, '0);
    check("t7_cnt_sat", conflict_cnt, 16'hFFFF);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t7_rst_ready", issue_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t7_rst_cnt", conflict_cnt, 0);
    check("t7_rst_valid", ex_valid, 0);
    check("t7_rst_rd", ex_rd, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
